// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU sequencer.
//   state_t    - control FSM states (IDLE, DRIVE, RESP)
//   WIDTH_DEF  - default datapath width
//   CNT_W      - width of the settle counter (SETTLE range 1..15)
package alu_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_fchk.sv
// alu_seq_fchk: combinational consistency check of ALU flags against result.
// Ports:
//   w        in  WIDTH  ALU result
//   zer      in  1      ALU zero flag
//   neg      in  1      ALU negative flag
//   mismatch out 1      1 when zer/neg do not describe w
module alu_seq_fchk #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] w,
  input  logic             zer,
  input  logic             neg,
  output logic             mismatch
);

  assign mismatch = (zer != (w == '0)) || (neg != w[WIDTH-1]);

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequential master for a combinational ALU.
// Accepts load / ALU-op commands over cmd valid/ready, holds the ALU operands
// stable for SETTLE cycles, captures result and flags into the accumulator
// and flag registers, and returns them over res valid/ready.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cmd_valid/ready               command handshake
//   cmd_load, cmd_opc, cmd_data,
//   cmd_cin                       command fields
//   alu_opc, alu_a, alu_b,
//   alu_cin                       registered ALU operands (a = accumulator)
//   alu_w, alu_zer, alu_neg       ALU result and flags
//   res_valid/ready               result handshake
//   res_data, res_zer, res_neg    accumulator and captured flags
//   flag_err                      sticky flag-inconsistency indicator
//   op_count                      completed responses, wraps mod 256
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = 1          // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_opc,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_cin,
  output logic [2:0]       alu_opc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zer,
  output logic             res_neg,
  output logic             flag_err,
  output logic [7:0]       op_count
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             flag_mismatch;

  alu_seq_fchk #(.WIDTH(WIDTH)) u_fchk (
    .w        (alu_w),
    .zer      (alu_zer),
    .neg      (alu_neg),
    .mismatch (flag_mismatch)
  );

  // Gated by rst so the block refuses commands for the whole reset pulse.
  assign cmd_ready = (state == IDLE) && !rst;
  // The accumulator only changes in IDLE/DRIVE, so it is stable during RESP.
  assign res_data  = acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      alu_opc   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      res_valid <= 1'b0;
      res_zer   <= 1'b0;
      res_neg   <= 1'b0;
      flag_err  <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is 1 here, so cmd_valid alone is the handshake.
          if (cmd_valid) begin
            if (cmd_load) begin
              acc       <= cmd_data;
              res_zer   <= (cmd_data == '0);
              res_neg   <= cmd_data[WIDTH-1];
              res_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_opc <= cmd_opc;
              alu_a   <= acc;
              alu_b   <= cmd_data;
              alu_cin <= cmd_cin;
              cnt     <= CNT_W'(SETTLE - 1);
              state   <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            acc       <= alu_w;
            res_zer   <= alu_zer;
            res_neg   <= alu_neg;
            res_valid <= 1'b1;
            if (flag_mismatch) flag_err <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl. Two instances share the
// command fields: u_s1 (SETTLE=1) and u_s4 (SETTLE=4), each with its own
// cmd_valid and its own behavioural ALU (opc 0 add, 1 sub, 7 faulty, else and).
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_load;
  logic [2:0]  cmd_opc;
  logic [15:0] cmd_data;
  logic        cmd_cin;
  logic        res_ready;

  logic        cmd_valid_s1, cmd_ready_s1, alu_cin_s1, alu_zer_s1, alu_neg_s1;
  logic [2:0]  alu_opc_s1;
  logic [15:0] alu_a_s1, alu_b_s1, alu_w_s1, res_data_s1;
  logic        res_valid_s1, res_zer_s1, res_neg_s1, flag_err_s1;
  logic [7:0]  op_count_s1;

  logic        cmd_valid_s4, cmd_ready_s4, alu_cin_s4, alu_zer_s4, alu_neg_s4;
  logic [2:0]  alu_opc_s4;
  logic [15:0] alu_a_s4, alu_b_s4, alu_w_s4, res_data_s4;
  logic        res_valid_s4, res_zer_s4, res_neg_s4, flag_err_s4;
  logic [7:0]  op_count_s4;

  logic        ref_mismatch;

  int checks = 0;
  int errors = 0;

  function automatic logic [17:0] alu_model(input logic [2:0] opc, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
    logic [15:0] w;
    logic        zer, neg;
    case (opc)
      3'd0:    w = a + b + {15'd0, cin};
      3'd1:    w = a - b;
      3'd7:    w = 16'h0005;
      default: w = a & b;
    endcase
    zer = (w == 16'd0);
    neg = w[15];
    if (opc == 3'd7) begin
      zer = 1'b1;
      neg = 1'b0;
    end
    return {w, zer, neg};
  endfunction

  always_comb {alu_w_s1, alu_zer_s1, alu_neg_s1} = alu_model(alu_opc_s1, alu_a_s1, alu_b_s1, alu_cin_s1);
  always_comb {alu_w_s4, alu_zer_s4, alu_neg_s4} = alu_model(alu_opc_s4, alu_a_s4, alu_b_s4, alu_cin_s4);

  alu_seq_ctrl #(.WIDTH(16), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_s1), .cmd_ready(cmd_ready_s1),
    .cmd_load(cmd_load), .cmd_opc(cmd_opc), .cmd_data(cmd_data), .cmd_cin(cmd_cin),
    .alu_opc(alu_opc_s1), .alu_a(alu_a_s1), .alu_b(alu_b_s1), .alu_cin(alu_cin_s1),
    .alu_w(alu_w_s1), .alu_zer(alu_zer_s1), .alu_neg(alu_neg_s1),
    .res_valid(res_valid_s1), .res_ready(res_ready), .res_data(res_data_s1),
    .res_zer(res_zer_s1), .res_neg(res_neg_s1), .flag_err(flag_err_s1), .op_count(op_count_s1)
  );

  alu_seq_ctrl #(.WIDTH(16), .SETTLE(4)) u_s4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_s4), .cmd_ready(cmd_ready_s4),
    .cmd_load(cmd_load), .cmd_opc(cmd_opc), .cmd_data(cmd_data), .cmd_cin(cmd_cin),
    .alu_opc(alu_opc_s4), .alu_a(alu_a_s4), .alu_b(alu_b_s4), .alu_cin(alu_cin_s4),
    .alu_w(alu_w_s4), .alu_zer(alu_zer_s4), .alu_neg(alu_neg_s4),
    .res_valid(res_valid_s4), .res_ready(res_ready), .res_data(res_data_s4),
    .res_zer(res_zer_s4), .res_neg(res_neg_s4), .flag_err(flag_err_s4), .op_count(op_count_s4)
  );

  alu_seq_fchk #(.WIDTH(16)) u_ref (
    .w(alu_w_s1), .zer(alu_zer_s1), .neg(alu_neg_s1), .mismatch(ref_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command to u_s1 and wait (bounded) for its response; no pop.
  task automatic run_op_s1(input logic load, input logic [2:0] opc,
                           input logic [15:0] data, input logic cin);
    int n;
    cmd_load = load; cmd_opc = opc; cmd_data = data; cmd_cin = cin;
    cmd_valid_s1 = 1'b1;
    step();
    cmd_valid_s1 = 1'b0;
    n = 0;
    while (res_valid_s1 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (res_valid_s1 !== 1'b1) begin
      errors++;
      $display("FAIL op_timeout: res_valid=%0b want 1 after %0d cycles", res_valid_s1, n);
    end
  endtask

  task automatic pop_s1();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid_s1 = 0; cmd_valid_s4 = 0; cmd_load = 0; cmd_opc = 0;
    cmd_data = 0; cmd_cin = 0; res_ready = 0;
    step(); step();
    checks++; if (cmd_ready_s1 !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready_s1); end
    checks++; if (res_valid_s1 !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %0b want 0", res_valid_s1); end
    checks++; if ({res_data_s1, alu_a_s1, alu_b_s1} !== 48'd0) begin errors++; $display("FAIL rst_data: got %h want 0", {res_data_s1, alu_a_s1, alu_b_s1}); end
    checks++; if ({flag_err_s1, op_count_s1, op_count_s4} !== 17'd0) begin errors++; $display("FAIL rst_counts: got %h want 0", {flag_err_s1, op_count_s1, op_count_s4}); end
    #3 rst = 1'b0;
    step();
    checks++; if (cmd_ready_s1 !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %0b want 1", cmd_ready_s1); end
  endtask

  task automatic test_load_pop();
    res_ready = 1'b1;
    cmd_load = 1'b1; cmd_data = 16'h0000; cmd_valid_s1 = 1'b1;
    step();
    cmd_valid_s1 = 1'b0;
    checks++; if (res_valid_s1 !== 1'b1) begin errors++; $display("FAIL load_valid: got %0b want 1", res_valid_s1); end
    checks++; if ({res_data_s1, res_zer_s1, res_neg_s1} !== {16'h0000, 1'b1, 1'b0}) begin errors++; $display("FAIL load_res: got %h/%0b/%0b want 0000/1/0", res_data_s1, res_zer_s1, res_neg_s1); end
    step();
    res_ready = 1'b0;
    checks++; if (res_valid_s1 !== 1'b0 || op_count_s1 !== 8'd1) begin errors++; $display("FAIL load_pop: valid=%0b count=%0d want 0/1", res_valid_s1, op_count_s1); end
  endtask

  task automatic test_alu_add();
    run_op_s1(1'b1, 3'd0, 16'h7FFF, 1'b0);
    pop_s1();
    cmd_load = 1'b0; cmd_opc = 3'd0; cmd_data = 16'h0001; cmd_cin = 1'b0; cmd_valid_s1 = 1'b1;
    step();
    cmd_valid_s1 = 1'b0;
    checks++; if (alu_a_s1 !== 16'h7FFF || alu_b_s1 !== 16'h0001) begin errors++; $display("FAIL add_operands: a=%h b=%h want 7fff/0001", alu_a_s1, alu_b_s1); end
    checks++; if (cmd_ready_s1 !== 1'b0 || res_valid_s1 !== 1'b0) begin errors++; $display("FAIL add_drive: ready=%0b valid=%0b want 0/0", cmd_ready_s1, res_valid_s1); end
    step();
    checks++; if (res_valid_s1 !== 1'b1) begin errors++; $display("FAIL add_latency: valid=%0b want 1", res_valid_s1); end
    checks++; if ({res_data_s1, res_zer_s1, res_neg_s1} !== {16'h8000, 1'b0, 1'b1}) begin errors++; $display("FAIL add_res: got %h/%0b/%0b want 8000/0/1", res_data_s1, res_zer_s1, res_neg_s1); end
    checks++; if (alu_a_s1 !== 16'h7FFF || flag_err_s1 !== 1'b0) begin errors++; $display("FAIL add_hold: a=%h err=%0b want 7fff/0", alu_a_s1, flag_err_s1); end
    pop_s1();
    checks++; if (res_valid_s1 !== 1'b0 || op_count_s1 !== 8'd3) begin errors++; $display("FAIL add_pop: valid=%0b count=%0d want 0/3", res_valid_s1, op_count_s1); end
  endtask

  task automatic test_settle4();
    res_ready = 1'b0;
    cmd_load = 1'b0; cmd_opc = 3'd0; cmd_data = 16'h00F0; cmd_cin = 1'b1; cmd_valid_s4 = 1'b1;
    step();
    cmd_valid_s4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if ({alu_a_s4, alu_b_s4, alu_cin_s4} !== {16'h0000, 16'h00F0, 1'b1}) begin errors++; $display("FAIL s4_operands[%0d]: a=%h b=%h c=%0b", k, alu_a_s4, alu_b_s4, alu_cin_s4); end
      checks++; if (res_valid_s4 !== 1'b0 || cmd_ready_s4 !== 1'b0) begin errors++; $display("FAIL s4_drive[%0d]: valid=%0b ready=%0b want 0/0", k, res_valid_s4, cmd_ready_s4); end
    end
    // Stray command while busy must be ignored.
    cmd_load = 1'b1; cmd_data = 16'hFFFF; cmd_valid_s4 = 1'b1;
    step();
    checks++; if (res_valid_s4 !== 1'b1 || res_data_s4 !== 16'h00F1) begin errors++; $display("FAIL s4_result: valid=%0b data=%h want 1/00f1", res_valid_s4, res_data_s4); end
    checks++; if (alu_b_s4 !== 16'h00F0) begin errors++; $display("FAIL s4_alu_hold: b=%h want 00f0", alu_b_s4); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (res_valid_s4 !== 1'b1 || res_data_s4 !== 16'h00F1 || cmd_ready_s4 !== 1'b0) begin errors++; $display("FAIL s4_wait[%0d]: valid=%0b data=%h ready=%0b", k, res_valid_s4, res_data_s4, cmd_ready_s4); end
    end
    res_ready = 1'b1;
    step();
    cmd_valid_s4 = 1'b0;
    res_ready = 1'b0;
    checks++; if (res_valid_s4 !== 1'b0 || op_count_s4 !== 8'd1 || res_data_s4 !== 16'h00F1) begin errors++; $display("FAIL s4_pop: valid=%0b count=%0d data=%h", res_valid_s4, op_count_s4, res_data_s4); end
    step();
    checks++; if (cmd_ready_s4 !== 1'b1 || res_valid_s4 !== 1'b0) begin errors++; $display("FAIL s4_idle: ready=%0b valid=%0b want 1/0", cmd_ready_s4, res_valid_s4); end
  endtask

  task automatic test_reset_mid();
    cmd_load = 1'b0; cmd_opc = 3'd0; cmd_data = 16'h0003; cmd_cin = 1'b0; cmd_valid_s4 = 1'b1;
    step();
    cmd_valid_s4 = 1'b0;
    step();
    #3 rst = 1'b1;
    #1;
    checks++; if (res_data_s4 !== 16'h0000 || op_count_s4 !== 8'd0 || cmd_ready_s4 !== 1'b0) begin errors++; $display("FAIL rst_drive: data=%h count=%0d ready=%0b", res_data_s4, op_count_s4, cmd_ready_s4); end
    #1 rst = 1'b0;
    step();
    cmd_load = 1'b1; cmd_data = 16'hABCD; cmd_valid_s1 = 1'b1;
    step();
    cmd_valid_s1 = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++; if (res_valid_s1 !== 1'b0 || cmd_ready_s1 !== 1'b0 || res_data_s1 !== 16'h0000) begin errors++; $display("FAIL rst_resp: valid=%0b ready=%0b data=%h", res_valid_s1, cmd_ready_s1, res_data_s1); end
    #1 rst = 1'b0;
    step();
    run_op_s1(1'b1, 3'd0, 16'h8001, 1'b0);
    pop_s1();
    checks++; if ({res_data_s1, res_neg_s1, res_zer_s1} !== {16'h8001, 1'b1, 1'b0} || op_count_s1 !== 8'd1) begin errors++; $display("FAIL rst_recover: data=%h neg=%0b zer=%0b count=%0d", res_data_s1, res_neg_s1, res_zer_s1, op_count_s1); end
  endtask

  task automatic test_flag_err();
    run_op_s1(1'b0, 3'd7, 16'h0000, 1'b0);
    checks++; if ({res_data_s1, res_zer_s1, res_neg_s1} !== {16'h0005, 1'b1, 1'b0}) begin errors++; $display("FAIL bad_capture: got %h/%0b/%0b want 0005/1/0", res_data_s1, res_zer_s1, res_neg_s1); end
    checks++; if (flag_err_s1 !== 1'b1 || ref_mismatch !== 1'b1) begin errors++; $display("FAIL bad_flag: err=%0b ref=%0b want 1/1", flag_err_s1, ref_mismatch); end
    pop_s1();
    for (int k = 1; k <= 3; k++) begin
      run_op_s1(1'b0, 3'd0, 16'h0001, 1'b0);
      checks++; if (res_data_s1 !== 16'(5 + k) || flag_err_s1 !== 1'b1 || ref_mismatch !== 1'b0) begin errors++; $display("FAIL sticky[%0d]: data=%h err=%0b ref=%0b", k, res_data_s1, flag_err_s1, ref_mismatch); end
      pop_s1();
    end
    #3 rst = 1'b1;
    #1;
    checks++; if (flag_err_s1 !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", flag_err_s1); end
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int responses = 0;
    cmd_load = 1'b1;
    res_ready = 1'b1;
    cmd_valid_s1 = 1'b1;
    for (int n = 1; n <= 512; n++) begin
      cmd_data = 16'(n);
      step();
      if (res_valid_s1 === 1'b1) responses++;
      checks++; if (res_valid_s1 !== 1'(n % 2)) begin errors++; $display("FAIL b2b_period[%0d]: valid=%0b", n, res_valid_s1); end
      if (n % 2 == 1) begin
        checks++; if (res_data_s1 !== 16'(n)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", n, res_data_s1, 16'(n)); end
      end
      if (n == 510) begin
        checks++; if (op_count_s1 !== 8'd255) begin errors++; $display("FAIL b2b_count255: got %0d want 255", op_count_s1); end
      end
    end
    cmd_valid_s1 = 1'b0;
    res_ready = 1'b0;
    checks++; if (responses != 256 || op_count_s1 !== 8'd0) begin errors++; $display("FAIL b2b_wrap: responses=%0d count=%0d want 256/0", responses, op_count_s1); end
  endtask

  initial begin
    test_reset();
    test_load_pop();
    test_alu_add();
    test_settle4();
    test_reset_mid();
    test_flag_err();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
